// File: rtl/scaled_stream_framer_if.sv
// scaled_stream_framer_if: pixel stream into and tagged pixel stream out of the framer.
// master = surrounding logic, slave = the framer itself.
interface scaled_stream_framer_if;
  logic in_valid, in_ready, out_valid, out_ready, out_sof, out_eol, out_eof;
  logic [7:0] in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sof, out_eol, out_eof);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sof, out_eol, out_eof);
endinterface

// File: rtl/scaled_stream_framer.sv
// scaled_stream_framer: tags a raster pixel stream with sof/eol/eof, inserts line blanking, 4-deep output FIFO.
// Optional frame checksum enabled by defining FRAMER_CHECKSUM_EN.
module scaled_stream_framer #(
  parameter int COLS = 494,
  parameter int ROWS = 484,
  parameter int HBLANK = 2
) (
  input  logic clk,
  input  logic rst_n,
  scaled_stream_framer_if.slave s,
  output logic frame_done,
  output logic [15:0] frame_sum
);
  typedef enum logic [1:0] {S_IDLE, S_LINE, S_HBLANK, S_DONE} state_t;
  state_t state;
  logic run, push, pop, sof, eol, eof;
  logic [9:0] col_cnt, row_cnt;
  logic [3:0] hb_cnt;
  logic [10:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  // run keeps in_ready low while in reset and rises on the first edge after release
  assign s.in_ready = run && (state == S_IDLE || state == S_LINE) && count != 3'd4;
  assign push = s.in_valid && s.in_ready;
  assign pop = s.out_valid && s.out_ready;
  assign sof = state == S_IDLE;
  assign eol = col_cnt == 10'(COLS - 1);
  assign eof = eol && row_cnt == 10'(ROWS - 1);
  assign s.out_valid = count != 3'd0;
  assign {s.out_sof, s.out_eol, s.out_eof, s.out_data} = s.out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      run <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
      hb_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      run <= 1'b1;
      frame_done <= 1'b0;
      case (state)
        S_IDLE, S_LINE: if (push) begin
          col_cnt <= eol ? '0 : col_cnt + 10'd1;
          row_cnt <= eol ? row_cnt + 10'd1 : row_cnt;
          frame_done <= eof;
          hb_cnt <= 4'(HBLANK - 1);
          state <= eof ? S_DONE : (eol && HBLANK != 0) ? S_HBLANK : S_LINE;
        end
        S_HBLANK: begin
          hb_cnt <= hb_cnt - 4'd1;
          state <= hb_cnt == 4'd0 ? S_LINE : S_HBLANK;
        end
        S_DONE: begin
          col_cnt <= '0;
          row_cnt <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + 2'(push);
      rd_ptr <= rd_ptr + 2'(pop);
      count <= count + 3'(push) - 3'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {sof, eol, eof, s.in_data};
`ifdef FRAMER_CHECKSUM_EN
  logic [15:0] acc;
  // frame_sum is loaded on the eof transfer so it is valid alongside frame_done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      frame_sum <= '0;
    end else if (push) begin
      acc <= (sof ? 16'd0 : acc) + 16'(s.in_data);
      if (eof) frame_sum <= acc + 16'(s.in_data);
    end
`else
  assign frame_sum = '0;
`endif
endmodule

// File: tb/tb_scaled_stream_framer.sv
// tb_scaled_stream_framer: directed checks of tagging, blanking, FIFO backpressure, reset and checksum.
module tb_scaled_stream_framer;
`ifdef FRAMER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic a_done, b_done;
  logic [15:0] a_sum, b_sum;
  int checks = 0, failures = 0;
  int nxt, last, got, base, acc_n, done_n, low_n;
  bit ff, lat;
  logic [15:0] exp_sum;
  always #5 clk = ~clk;
  scaled_stream_framer_if a();
  scaled_stream_framer_if b();
  scaled_stream_framer #(.COLS(4), .ROWS(2), .HBLANK(2)) dut_a (.clk(clk), .rst_n(rst_n), .s(a), .frame_done(a_done), .frame_sum(a_sum));
  scaled_stream_framer #(.COLS(2), .ROWS(2), .HBLANK(0)) dut_b (.clk(clk), .rst_n(rst_n), .s(b), .frame_done(b_done), .frame_sum(b_sum));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // drives pixels nxt..last into a, checks every popped output against its frame position
  task automatic stream_a(input int ncyc, input logic ordy);
    int k;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      a.out_ready = ordy;
      if (lat) chk("a_latency", a.out_valid, 1'b1);
      if (a.out_valid && a.out_ready) begin
        k = (got - base) % 8;
        chk("a_data", a.out_data, ff ? 8'hFF : 8'(got));
        chk("a_sof", a.out_sof, k == 0);
        chk("a_eol", a.out_eol, k == 3 || k == 7);
        chk("a_eof", a.out_eof, k == 7);
        got++;
      end
      if (a_done) begin
        done_n++;
        chk("a_sum", a_sum, exp_sum);
      end
      if (!a.in_ready && nxt > base && nxt <= last && (nxt - base) % 8 != 0) low_n++;
      a.in_valid = nxt <= last;
      a.in_data = ff ? 8'hFF : 8'(nxt);
      lat = a.in_valid && a.in_ready && !a.out_valid;
      if (a.in_valid && a.in_ready) begin
        acc_n++;
        nxt++;
      end
    end
  endtask
  initial begin
    a.in_valid = 0; a.in_data = 0; a.out_ready = 0;
    b.in_valid = 0; b.in_data = 0; b.out_ready = 1;
    lat = 0; ff = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", a.out_valid, 1'b0);
    chk("rst_out_data", a.out_data, 8'h00);
    chk("rst_tags", {a.out_sof, a.out_eol, a.out_eof}, 3'b000);
    chk("rst_in_ready", a.in_ready, 1'b0);
    chk("rst_frame_done", a_done, 1'b0);
    chk("rst_frame_sum", a_sum, 16'h0000);
    rst_n = 1;
    #1 chk("in_ready_before_edge", a.in_ready, 1'b0);
    @(negedge clk);
    chk("in_ready_after_edge", a.in_ready, 1'b1);
    // frame 1..8 with free-running output
    nxt = 1; last = 8; got = 1; base = 1; acc_n = 0; done_n = 0; low_n = 0;
    exp_sum = CK ? 16'd36 : 16'd0;
    stream_a(20, 1'b1);
    chk("t1_outputs", 16'(got), 16'd9);
    chk("t1_accepted", 16'(acc_n), 16'd8);
    chk("t1_done_pulses", 16'(done_n), 16'd1);
    chk("t1_hblank_stall", 16'(low_n), 16'd2);
    chk("t1_sum_held", a_sum, exp_sum);
    // backpressure: FIFO fills to 4 then stalls
    nxt = 1; got = 1; acc_n = 0; done_n = 0;
    stream_a(10, 1'b0);
    chk("t3_accepted_full", 16'(acc_n), 16'd4);
    chk("t3_in_ready_full", a.in_ready, 1'b0);
    chk("t3_head_hold", {a.out_valid, a.out_sof, a.out_data}, {1'b1, 1'b1, 8'd1});
    stream_a(20, 1'b1);
    chk("t3_outputs", 16'(got), 16'd9);
    chk("t3_accepted", 16'(acc_n), 16'd8);
    chk("t3_done_pulses", 16'(done_n), 16'd1);
    // HBLANK=0 instance: no stall between lines, only DONE drops in_ready
    @(negedge clk);
    chk("b_ready0", b.in_ready, 1'b1);
    b.in_valid = 1; b.in_data = 1;
    @(negedge clk);
    chk("b_ready1", b.in_ready, 1'b1);
    chk("b_px1", {b.out_valid, b.out_sof, b.out_eol, b.out_eof, b.out_data}, {4'b1100, 8'd1});
    b.in_data = 2;
    @(negedge clk);
    chk("b_ready2", b.in_ready, 1'b1);
    chk("b_px2", {b.out_valid, b.out_sof, b.out_eol, b.out_eof, b.out_data}, {4'b1010, 8'd2});
    b.in_data = 3;
    @(negedge clk);
    chk("b_ready3", b.in_ready, 1'b1);
    chk("b_px3", {b.out_valid, b.out_sof, b.out_eol, b.out_eof, b.out_data}, {4'b1000, 8'd3});
    b.in_data = 4;
    @(negedge clk);
    chk("b_done_ready", b.in_ready, 1'b0);
    chk("b_done", b_done, 1'b1);
    chk("b_sum", b_sum, CK ? 16'd10 : 16'd0);
    chk("b_px4", {b.out_valid, b.out_sof, b.out_eol, b.out_eof, b.out_data}, {4'b1011, 8'd4});
    b.in_valid = 0;
    @(negedge clk);
    chk("b_idle_ready", b.in_ready, 1'b1);
    chk("b_done_end", b_done, 1'b0);
    // reset mid-frame discards the FIFO, next pixel starts a new frame
    nxt = 1; last = 3; got = 1; base = 1; acc_n = 0; done_n = 0;
    stream_a(5, 1'b0);
    chk("t5_accepted", 16'(acc_n), 16'd3);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("t5_rst_out_valid", a.out_valid, 1'b0);
    chk("t5_rst_out_data", a.out_data, 8'h00);
    chk("t5_rst_in_ready", a.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1;
    lat = 0;
    nxt = 9; last = 16; got = 9; base = 9; acc_n = 0; done_n = 0;
    exp_sum = CK ? 16'd100 : 16'd0;
    stream_a(25, 1'b1);
    chk("t5_outputs", 16'(got), 16'd17);
    chk("t5_done_pulses", 16'(done_n), 16'd1);
    // back-to-back 0xFF frames
    ff = 1; nxt = 1; last = 16; got = 1; base = 1; acc_n = 0; done_n = 0;
    exp_sum = CK ? 16'h07F8 : 16'd0;
    stream_a(45, 1'b1);
    chk("t6_outputs", 16'(got), 16'd17);
    chk("t6_done_pulses", 16'(done_n), 16'd2);
    chk("t6_sum_held", a_sum, exp_sum);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scaled_stream_framer.md
SCALED_STREAM_FRAMER -- requirements
Module: scaled_stream_framer

Interface
REQ-001 SHALL have parameter COLS, default 494, pixels per scaled line (2..1024).
REQ-002 SHALL have parameter ROWS, default 484, lines per scaled frame (2..1024).
REQ-003 SHALL have parameter HBLANK, default 2, stall cycles inserted after each line (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports in_valid  input  1 and in_data  input  8  scaled pixel stream from the scaler, raster order.
REQ-007 SHALL have port in_ready  output  1  upstream handshake.
REQ-008 SHALL have ports out_valid  output  1 and out_data  output  8  tagged pixel stream.
REQ-009 SHALL have port out_ready  input  1  downstream handshake.
REQ-010 SHALL have ports out_sof, out_eol, out_eof  output  1 each  tags qualified by out_valid.
REQ-011 SHALL have ports frame_done  output  1  one-cycle pulse, and frame_sum  output  16  frame checksum.

Function
REQ-012 SHALL treat a transfer as valid&ready high on the same clk edge, on both sides.
REQ-013 SHALL keep 10-bit col_cnt and row_cnt, advanced only on accepted input pixels.
REQ-014 SHALL have states IDLE, LINE, HBLANK, DONE.
REQ-015 IDLE: in_ready = fifo not full; first accepted pixel tagged sof, col_cnt=1, go LINE.
REQ-016 LINE: in_ready = fifo not full; pixel with col_cnt==COLS-1 tagged eol, col_cnt->0, row_cnt+1, go HBLANK (or DONE if also row_cnt==ROWS-1).
REQ-017 HBLANK: in_ready=0 for exactly HBLANK cycles, then LINE; HBLANK=0 goes straight to LINE with no stall cycle.
REQ-018 Last pixel of frame (row ROWS-1, col COLS-1) SHALL carry eol and eof; state goes DONE.
REQ-019 DONE: in_ready=0 for one cycle, frame_done=1 that cycle, counters cleared, then IDLE.
REQ-020 SHALL buffer pixel+tags (11 bits) in a 4-entry FIFO; out_* driven from FIFO head.
REQ-021 Latency: pixel accepted at edge N SHALL present out_valid at N+1 if FIFO was empty.
REQ-022 in_ready SHALL depend only on FIFO count<4 and state, never combinationally on out_ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 out_data/tags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 frame_done SHALL fire at input acceptance of the eof pixel's frame end, independent of output drain.

Reset
REQ-026 On rst_n=0: state IDLE, counters 0, FIFO empty, out_valid=0, out_data=0, tags 0, in_ready=0, frame_done=0, frame_sum=0.
REQ-027 Reset mid-frame SHALL discard FIFO contents; next accepted pixel after release is sof.
REQ-028 in_ready SHALL rise the first edge after rst_n deasserts.

Configuration
REQ-029 Macro FRAMER_CHECKSUM_EN defined: 16-bit running sum of accepted in_data mod 65536, cleared at sof, latched into frame_sum at the DONE cycle, held until next DONE.
REQ-030 FRAMER_CHECKSUM_EN undefined: no accumulator; frame_sum constant 0; all other behaviour identical.

Verification
REQ-031 COLS=4,ROWS=2,HBLANK=2, pixels 1..8 continuous, out_ready=1 -> outputs 1..8, sof on 1, eol on 4 and 8, eof on 8, in_ready low 2 cycles after pixel 4.
REQ-032 Same, checksum enabled -> frame_done one pulse, frame_sum=36; disabled -> frame_sum=0.
REQ-033 out_ready=0, in_valid=1 -> exactly 4 accepted, in_ready=0 thereafter; release -> order preserved, no loss.
REQ-034 HBLANK=0, COLS=2,ROWS=2 -> no stall between lines; only DONE cycle drops in_ready.
REQ-035 rst_n low after pixel 3 of frame -> out_valid=0 immediately; next pixel 9 tagged sof.
REQ-036 Back-to-back frames, pixels 0xFF x8 -> second frame sof correct, frame_sum=0x07F8 both frames.
